// File: rtl/exp_spike_scheduler.sv
// -----------------------------------------------------------------------------
// exp_spike_scheduler
//
// Several spike channels share one exponential sample source. A channel that
// is waiting for a new interval asks for the current sample; a round-robin
// arbiter lets at most one channel take the sample each cycle. The granted
// channel loads the clamped and scaled sample into its interval counter and
// counts down. When the counter expires, the channel emits a one-cycle spike
// and asks for the next sample.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   en_i         : per-channel enable (level); low forces the channel idle
//   scale_i      : right shift applied to every sample before it is loaded
//   prng_i       : signed exponential sample, new value every cycle
//   gnt_o        : combinational one-hot/zero grant (channel taking prng_i)
//   spike_o      : registered one-cycle spike pulse per channel
//   ready_o      : registered, high once the source warm-up time has passed
//   dbg_state_o  : per-channel state, 2 bits per channel (0 idle,1 req,2 count)
//   dbg_cnt_o    : per-channel interval counter, X_WID bits per channel
//   dbg_ptr_o    : round-robin search start pointer
//
// Handshake: the channel-side request is a level that is re-evaluated every
// cycle. A requester is granted in the cycle gnt_o shows it and takes the
// sample present on prng_i in that same cycle at the next rising edge. There
// is no back-pressure on the source and no sample is ever stored; a requester
// that loses simply asks again next cycle.
// -----------------------------------------------------------------------------
module exp_spike_scheduler #(
   parameter int NUM_CH = 4,
   parameter int X_WID  = 16,
   parameter int WARMUP = 2,
   localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_CH-1:0]         en_i,
   input  logic [3:0]                scale_i,
   input  logic [X_WID-1:0]          prng_i,
   output logic [NUM_CH-1:0]         gnt_o,
   output logic [NUM_CH-1:0]         spike_o,
   output logic                      ready_o,
   output logic [2*NUM_CH-1:0]       dbg_state_o,
   output logic [NUM_CH*X_WID-1:0]   dbg_cnt_o,
   output logic [PW-1:0]             dbg_ptr_o
);

   localparam int WW = $clog2(WARMUP + 2);
   localparam logic [WW-1:0] WARMUP_W = WW'(WARMUP);

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_REQ   = 2'd1,
      CH_COUNT = 2'd2
   } ch_state_e;

   ch_state_e         state_q [NUM_CH];
   ch_state_e         state_d [NUM_CH];
   logic [X_WID-1:0]  cnt_q   [NUM_CH];
   logic [X_WID-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] spike_q;
   logic [NUM_CH-1:0] spike_d;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     ptr_d;
   logic [PW-1:0]     gnt_idx;
   logic              gnt_vld;
   int                idx;
   logic [WW-1:0]     wcnt_q;
   logic [WW-1:0]     wcnt_d;
   logic              ready_q;
   logic              ready_d;
   logic [X_WID-1:0]  sample_pos;
   logic [X_WID-1:0]  shifted;
   logic [X_WID-1:0]  load_val;

   // Negative samples are clamped to zero, and a zero interval is bumped to
   // one so a loaded channel always spends at least one edge counting.
   always_comb begin
      sample_pos = prng_i[X_WID-1] ? '0 : prng_i;
      shifted    = sample_pos >> scale_i;
      load_val   = (shifted == '0) ? X_WID'(1) : shifted;
   end

   // Requests are masked until the sample source has warmed up.
   always_comb begin
      req = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         req[c] = ready_q && en_i[c] && (state_q[c] == CH_REQ);
      end
   end

   // Round-robin: search upward from ptr_q, wrapping, first requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr_q) + i) % NUM_CH;
         if (!gnt_vld && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            gnt_vld  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Per-channel next state. Disable has priority over everything, including
   // a counter that is about to expire, so a late disable never spikes.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         spike_d[c] = 1'b0;
         if (!en_i[c]) begin
            state_d[c] = CH_IDLE;
            cnt_d[c]   = '0;
         end else begin
            case (state_q[c])
               CH_IDLE: state_d[c] = CH_REQ;
               CH_REQ: begin
                  if (gnt[c]) begin
                     cnt_d[c]   = load_val;
                     state_d[c] = CH_COUNT;
                  end
               end
               CH_COUNT: begin
                  if (cnt_q[c] == X_WID'(1)) begin
                     spike_d[c] = 1'b1;
                     cnt_d[c]   = '0;
                     state_d[c] = CH_REQ;
                  end else begin
                     cnt_d[c] = cnt_q[c] - 1'b1;
                  end
               end
               default: begin
                  state_d[c] = CH_IDLE;
                  cnt_d[c]   = '0;
               end
            endcase
         end
      end
   end

   // Warm-up counter stops once ready is reached; ready then holds.
   always_comb begin
      wcnt_d  = wcnt_q;
      ready_d = ready_q;
      if (!ready_q) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_d >= WARMUP_W) begin
            ready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= CH_IDLE;
            cnt_q[c]   <= '0;
         end
         spike_q <= '0;
         ptr_q   <= '0;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
         spike_q <= spike_d;
         ptr_q   <= ptr_d;
         wcnt_q  <= wcnt_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      dbg_state_o = '0;
      dbg_cnt_o   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         dbg_state_o[2*c +: 2]     = state_q[c];
         dbg_cnt_o[c*X_WID +: X_WID] = cnt_q[c];
      end
   end

   assign gnt_o     = gnt;
   assign spike_o   = spike_q;
   assign ready_o   = ready_q;
   assign dbg_ptr_o = ptr_q;

endmodule

// File: tb/tb_exp_spike_scheduler.sv
// -----------------------------------------------------------------------------
// tb_exp_spike_scheduler
//
// Directed bench for exp_spike_scheduler (NUM_CH=4, X_WID=16, WARMUP=2).
// A table of per-cycle {inputs, expected outputs} covers warm-up, the
// single-channel period and interval clamping; hand-written sequences cover
// round-robin contention, disable on the last count and reset mid-count.
// Cycle k means the clock period after the k-th rising edge following reset
// release; inputs are changed 2 time units after an edge and outputs are
// sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_exp_spike_scheduler;

   localparam int NUM_CH = 4;
   localparam int X_WID  = 16;

   logic                    clk;
   logic                    rst_ni;
   logic [NUM_CH-1:0]       en;
   logic [3:0]              scale;
   logic [X_WID-1:0]        prng;
   logic [NUM_CH-1:0]       gnt;
   logic [NUM_CH-1:0]       spike;
   logic                    ready;
   logic [2*NUM_CH-1:0]     dbg_state;
   logic [NUM_CH*X_WID-1:0] dbg_cnt;
   logic [1:0]              dbg_ptr;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  scale;
      logic [15:0] prng;
      logic [3:0]  gnt;
      logic [3:0]  spike;
      logic        ready;
   } vec_t;

   vec_t vecs[$];

   exp_spike_scheduler #(
      .NUM_CH (NUM_CH),
      .X_WID  (X_WID),
      .WARMUP (2)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .en_i        (en),
      .scale_i     (scale),
      .prng_i      (prng),
      .gnt_o       (gnt),
      .spike_o     (spike),
      .ready_o     (ready),
      .dbg_state_o (dbg_state),
      .dbg_cnt_o   (dbg_cnt),
      .dbg_ptr_o   (dbg_ptr)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic add(input logic [3:0] e, input logic [3:0] s, input logic [15:0] p,
                      input logic [3:0] g, input logic [3:0] sp, input logic r);
      vec_t v;
      v.en = e; v.scale = s; v.prng = p; v.gnt = g; v.spike = sp; v.ready = r;
      vecs.push_back(v);
   endtask

   // Hold reset for two edges with the given inputs, check the reset state,
   // then release; returns in cycle 0.
   task automatic reset_dut(input logic [3:0] e, input logic [3:0] s, input logic [15:0] p);
      rst_ni = 1'b0;
      en     = e;
      scale  = s;
      prng   = p;
      repeat (2) @(posedge clk);
      #2;
      check("reset spike", 32'(spike), 32'h0);
      check("reset ready", 32'(ready), 32'h0);
      check("reset gnt", 32'(gnt), 32'h0);
      check("reset state", 32'(dbg_state), 32'h0);
      check("reset ptr", 32'(dbg_ptr), 32'h0);
      rst_ni = 1'b1;
   endtask

   function automatic logic [15:0] cnt_of(input int c);
      return dbg_cnt[c*X_WID +: X_WID];
   endfunction

   function automatic logic [1:0] state_of(input int c);
      return dbg_state[2*c +: 2];
   endfunction

   // ---------------- stimulus and scoreboard ----------------
   initial begin
      logic [3:0] exp_g [10];
      logic [3:0] exp_s [10];
      logic [1:0] exp_p [10];

      checks = 0;
      errors = 0;
      rst_ni = 1'b0;
      en     = '0;
      scale  = '0;
      prng   = '0;

      // Warm-up and single-channel period (L=5, period 6), then clamping.
      add(4'h1, 4'd0, 16'd5, 4'h0, 4'h0, 1'b0);           // c0
      add(4'h1, 4'd0, 16'd5, 4'h0, 4'h0, 1'b0);           // c1
      add(4'h1, 4'd0, 16'd5, 4'h1, 4'h0, 1'b1);           // c2 first grant
      for (int k = 3; k <= 7; k++) add(4'h1, 4'd0, 16'd5, 4'h0, 4'h0, 1'b1);
      add(4'h1, 4'd0, 16'd5, 4'h1, 4'h1, 1'b1);           // c8 spike + grant
      for (int k = 9; k <= 13; k++) add(4'h1, 4'd0, 16'd5, 4'h0, 4'h0, 1'b1);
      add(4'h1, 4'd0, 16'd5, 4'h1, 4'h1, 1'b1);           // c14
      for (int k = 15; k <= 19; k++) add(4'h1, 4'd0, 16'd5, 4'h0, 4'h0, 1'b1);
      add(4'h1, 4'd0, 16'hFFFD, 4'h1, 4'h1, 1'b1);        // c20 sample -3 -> L=1
      add(4'h1, 4'd0, 16'hFFFD, 4'h0, 4'h0, 1'b1);        // c21
      add(4'h1, 4'd3, 16'd2, 4'h1, 4'h1, 1'b1);           // c22 2>>3=0 -> L=1
      add(4'h1, 4'd3, 16'd2, 4'h0, 4'h0, 1'b1);           // c23
      add(4'h1, 4'd3, 16'd2, 4'h1, 4'h1, 1'b1);           // c24
      add(4'h1, 4'd3, 16'd2, 4'h0, 4'h0, 1'b1);           // c25
      add(4'h1, 4'd3, 16'd2, 4'h1, 4'h1, 1'b1);           // c26

      reset_dut(4'h1, 4'd0, 16'd5);
      foreach (vecs[i]) begin
         en    = vecs[i].en;
         scale = vecs[i].scale;
         prng  = vecs[i].prng;
         #1;
         check($sformatf("table c%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         check($sformatf("table c%0d spike", i), 32'(spike), 32'(vecs[i].spike));
         check($sformatf("table c%0d ready", i), 32'(ready), 32'(vecs[i].ready));
         next_cycle();
      end

      // Contention: all channels, L=1, grants rotate 0,1,2,3 with ptr wrap.
      exp_g = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
      exp_s = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
      exp_p = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      reset_dut(4'hF, 4'd0, 16'd1);
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("rr c%0d gnt", k), 32'(gnt), 32'(exp_g[k]));
         check($sformatf("rr c%0d spike", k), 32'(spike), 32'(exp_s[k]));
         check($sformatf("rr c%0d ptr", k), 32'(dbg_ptr), 32'(exp_p[k]));
         next_cycle();
      end

      // Disable on the last count: load 3 at edge 3, cnt=1 in cycle 5.
      reset_dut(4'h1, 4'd0, 16'd3);
      repeat (5) next_cycle();
      #1;
      check("dis c5 cnt", 32'(cnt_of(0)), 32'd1);
      check("dis c5 state", 32'(state_of(0)), 32'd2);
      en = 4'h0;
      #1;
      check("dis c5 gnt", 32'(gnt), 32'h0);
      next_cycle();
      #1;
      check("dis c6 spike", 32'(spike), 32'h0);
      check("dis c6 state", 32'(state_of(0)), 32'd0);
      check("dis c6 cnt", 32'(cnt_of(0)), 32'd0);
      en = 4'h1;
      next_cycle();
      #1;
      check("dis c7 spike", 32'(spike), 32'h0);
      check("dis c7 gnt", 32'(gnt), 32'h1);
      en = 4'h0;
      #1;
      check("dis c7 gnt masked", 32'(gnt), 32'h0);
      check("dis c7 state", 32'(state_of(0)), 32'd1);

      // Reset mid-count on channel 2: load 10 at edge 3, cnt=7 in cycle 6.
      reset_dut(4'h4, 4'd0, 16'd10);
      repeat (2) next_cycle();
      #1;
      check("mid c2 gnt", 32'(gnt), 32'h4);
      repeat (4) next_cycle();
      #1;
      check("mid c6 cnt", 32'(cnt_of(2)), 32'd7);
      rst_ni = 1'b0;
      #1;
      check("mid rst gnt", 32'(gnt), 32'h0);
      check("mid rst spike", 32'(spike), 32'h0);
      check("mid rst ready", 32'(ready), 32'h0);
      check("mid rst cnt", 32'(dbg_cnt), 32'h0);
      check("mid rst state", 32'(dbg_state), 32'h0);
      check("mid rst ptr", 32'(dbg_ptr), 32'h0);
      next_cycle();
      rst_ni = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("mid post c%0d spike", k), 32'(spike), 32'h0);
         check($sformatf("mid post c%0d gnt", k), 32'(gnt), (k == 2) ? 32'h4 : 32'h0);
         check($sformatf("mid post c%0d ready", k), 32'(ready), (k == 2) ? 32'h1 : 32'h0);
         next_cycle();
      end
      #1;
      check("mid post c3 cnt", 32'(cnt_of(2)), 32'd10);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exp_spike_scheduler.md
EXP_SPIKE_SCHEDULER -- requirements
Module: exp_spike_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of spike channels sharing one exponential sample source.
REQ-002 SHALL have parameter X_WID, default 16: width of the signed sample input and of each channel's interval counter.
REQ-003 SHALL have parameter WARMUP, default 2: cycles after reset release before any sample is consumed (source LFSR plus ROM latency).
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en_i, input, NUM_CH: per-channel enable, level-sensitive.
REQ-007 SHALL have port scale_i, input, 4: global right-shift applied to every sample before loading, unsigned.
REQ-008 SHALL have port prng_i, input, X_WID: signed exponential sample from the shared generator; a new value is present every cycle.
REQ-009 SHALL have port gnt_o, output, NUM_CH: one-hot/zero, combinational; the channel consuming prng_i this cycle.
REQ-010 SHALL have port spike_o, output, NUM_CH: registered; one-cycle spike pulse per channel.
REQ-011 SHALL have port ready_o, output, 1: registered; high once the warm-up count has expired.

Function
REQ-012 SHALL hold per-channel state IDLE, REQ or COUNT, plus an X_WID-bit counter cnt.
REQ-013 SHALL move a channel from IDLE to REQ on the edge where en_i[c]=1.
REQ-014 SHALL make a channel in REQ with en_i[c]=1 a requester, and SHALL NOT raise any request while ready_o=0.
REQ-015 SHALL grant at most one requester per cycle, round-robin, searching upward from pointer ptr with wrap at NUM_CH-1 to 0.
REQ-016 SHALL set ptr to 0 at reset and, on each grant to channel g, set ptr to (g+1) mod NUM_CH; ptr SHALL be unchanged when there is no grant.
REQ-017 SHALL, on a grant to channel g, load cnt[g] with the load value L and move channel g to COUNT.
REQ-018 SHALL compute L as: s = 0 if prng_i is negative, else prng_i; L = s >> scale_i; if L = 0 then L = 1.
REQ-019 SHALL, on each edge in COUNT: if cnt = 1, set spike_o[c] to 1, set cnt to 0 and move the channel to REQ; otherwise decrement cnt.
REQ-020 SHALL clear spike_o[c] on every edge where REQ-019 does not set it; pulses SHALL be exactly one cycle.
REQ-021 SHALL make the spike timing follow from REQ-017/REQ-019: a load at edge t0 with value L puts spike_o[c] high in the cycle after edge t0+L.
REQ-022 SHALL give an uncontended channel a spike period of L+1 cycles.
REQ-023 SHALL let a channel that spikes win a grant no earlier than the following edge.
REQ-024 SHALL, when en_i[c]=0 at an edge in any state, move the channel to IDLE, clear cnt[c] and suppress the spike; disable wins over cnt = 1.
REQ-025 SHALL hold gnt_o[c] low whenever en_i[c]=0.
REQ-026 SHALL update a waiting channel's request each cycle and SHALL NOT store samples; a losing requester keeps waiting with no limit other than round-robin fairness, at most NUM_CH-1 cycles.
REQ-027 SHALL set ready_o to 1 on the edge when the warm-up counter reaches WARMUP, and ready_o SHALL then stay 1 until reset.

Reset
REQ-028 SHALL, while rst_ni=0, asynchronously force all channels to IDLE, every cnt to 0, ptr to 0, spike_o to 0, ready_o to 0 and the warm-up count to 0.
REQ-029 SHALL abort any in-flight countdown when reset is asserted mid-operation, with no spike emitted.
REQ-030 SHALL restart warm-up when rst_ni is released, before any new grant.

Verification
REQ-031 SHALL cover warm-up: release reset with en_i=4'b0001 and prng_i=5 -> gnt_o=0 for the first 2 cycles, ready_o high after the second edge, and a first grant in the next cycle.
REQ-032 SHALL cover single-channel period: en_i=4'b0001, scale_i=0, prng_i held at 5 -> spike_o[0] pulses every 6 cycles, each pulse exactly one cycle wide.
REQ-033 SHALL cover clamping: prng_i=-3 and then prng_i=2 with scale_i=3 -> L=1 in both cases, giving a 2-cycle period.
REQ-034 SHALL cover contention: en_i=4'b1111 with all channels in REQ -> grants on consecutive cycles to channels 0,1,2,3, with ptr wrapping back to 0.
REQ-035 SHALL cover disable during the final count: drop en_i[0] on the cycle when cnt[0]=1 -> no spike, and channel 0 reads IDLE with cnt=0.
REQ-036 SHALL cover mid-count reset: assert rst_ni=0 with cnt[2]=7 -> all outputs read 0 immediately, and after release there is no spike before warm-up completes and a new grant occurs.
